// File: rtl/uart_boot_loader_if.sv
// Byte-stream input, memory write port and boot status of the UART boot loader.
// The loader takes the master modport; the UART/memory side takes the slave modport.
interface uart_boot_loader_if;
    logic        rx_data_valid;
    logic [7:0]  rx_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        core_hold;
    logic        boot_go;
    logic [1:0]  err;

    modport master (
        input  rx_data_valid, rx_data, mem_ack,
        output mem_req, mem_addr, mem_wdata, core_hold, boot_go, err
    );

    modport slave (
        output rx_data_valid, rx_data, mem_ack,
        input  mem_req, mem_addr, mem_wdata, core_hold, boot_go, err
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Boot frame parser: SYNC | ADDR LE | LEN LE | LEN words LE | XOR checksum.
// Writes each word to memory and releases the core only after a verified frame.
module uart_boot_loader #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 100,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input logic               clk,
    input logic               rst,
    uart_boot_loader_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic        valid_prev_q;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] len_q, len_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] timer_q, timer_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        core_hold_q, core_hold_d;
    logic        boot_go_q, boot_go_d;
    logic [1:0]  err_q, err_d;

    logic        strobe;
    logic        acked;
    logic        in_frame;
    logic [31:0] asm_shift;

    assign strobe    = bus.rx_data_valid && !valid_prev_q;
    assign acked     = mem_req_q && bus.mem_ack;
    assign in_frame  = (state_q == S_ADDR) || (state_q == S_LEN) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
    assign asm_shift = {bus.rx_data, asm_q[31:8]};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        timer_d     = 32'd0;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        core_hold_d = core_hold_q;
        boot_go_d   = 1'b0;
        err_d       = err_q;

        if (acked) begin
            mem_req_d  = 1'b0;
            mem_addr_d = mem_addr_q + 32'd4;
        end

        if (in_frame && !strobe) begin
            timer_d = timer_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (strobe && bus.rx_data == SYNC_BYTE) begin
                    state_d     = S_ADDR;
                    core_hold_d = 1'b1;
                    csum_d      = 8'd0;
                    byte_cnt_d  = 2'd0;
                end
            end
            S_ADDR: begin
                if (strobe) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    asm_d      = asm_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (asm_shift[1:0] != 2'd0) begin
                            err_d   = 2'd3;
                            state_d = S_IDLE;
                        end else begin
                            mem_addr_d = asm_shift;
                            state_d    = S_LEN;
                        end
                    end
                end
            end
            S_LEN: begin
                if (strobe) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd0) begin
                        len_d[7:0] = bus.rx_data;
                    end else begin
                        len_d[15:8] = bus.rx_data;
                        byte_cnt_d  = 2'd0;
                        word_cnt_d  = 16'd0;
                        state_d     = ({bus.rx_data, len_q[7:0]} == 16'd0) ? S_CSUM : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (strobe) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    asm_d      = asm_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // A word may complete in the very cycle the previous one is acked.
                        if (mem_req_q && !bus.mem_ack) begin
                            err_d     = 2'd3;
                            mem_req_d = 1'b0;
                            state_d   = S_IDLE;
                        end else begin
                            mem_wdata_d = asm_shift;
                            mem_req_d   = 1'b1;
                            word_cnt_d  = word_cnt_q + 16'd1;
                            if (word_cnt_q == len_q - 16'd1) begin
                                state_d = S_CSUM;
                            end
                        end
                    end
                end
            end
            S_CSUM: begin
                if (strobe) begin
                    if (bus.rx_data == csum_q) begin
                        state_d = (mem_req_q && !bus.mem_ack) ? S_DRAIN : S_DONE;
                    end else begin
                        err_d   = 2'd1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (acked) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                boot_go_d   = 1'b1;
                core_hold_d = 1'b0;
                err_d       = 2'd0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (in_frame && !strobe && timer_q >= TIMEOUT_LAST) begin
            err_d     = 2'd2;
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q      <= S_IDLE;
            valid_prev_q <= 1'b0;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= 16'd0;
            len_q        <= 16'd0;
            asm_q        <= 32'd0;
            csum_q       <= 8'd0;
            timer_q      <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            core_hold_q  <= 1'b0;
            boot_go_q    <= 1'b0;
            err_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            valid_prev_q <= bus.rx_data_valid;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            len_q        <= len_d;
            asm_q        <= asm_d;
            csum_q       <= csum_d;
            timer_q      <= timer_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_hold_q  <= core_hold_d;
            boot_go_q    <= boot_go_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.core_hold = core_hold_q;
    assign bus.boot_go   = boot_go_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frames plus random frames checked against
// a frame-level model (expected write list, boot pulses, final status).
module tb_uart_boot_loader;
    localparam int unsigned CLK_FREQ = 100_000;
    localparam int unsigned TIMEOUT  = CLK_FREQ / 100;

    typedef logic [7:0] bytes_t[$];

    logic clk;
    logic rst;
    uart_boot_loader_if bus_if ();

    uart_boot_loader #(
        .CLK_FREQ      (CLK_FREQ),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int boot_cnt = 0;
    int ack_lat  = 3;
    bit ack_off  = 1'b0;
    int wcnt     = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory side: acks each request after ack_lat cycles and checks it against the model.
    always @(negedge clk) begin
        if (rst) begin
            bus_if.mem_ack = 1'b0;
            wcnt = 0;
        end else begin
            if (bus_if.boot_go) boot_cnt++;
            if (bus_if.mem_ack) begin
                bus_if.mem_ack = 1'b0;
                wcnt = 0;
            end else if (bus_if.mem_req) begin
                check("write_expected", 64'(exp_addr_q.size() != 0), 64'd1);
                if (exp_addr_q.size() != 0) begin
                    check("write_addr", 64'(bus_if.mem_addr), 64'(exp_addr_q[0]));
                    check("write_data", 64'(bus_if.mem_wdata), 64'(exp_data_q[0]));
                end
                if (!ack_off && wcnt >= ack_lat) begin
                    bus_if.mem_ack = 1'b1;
                    if (exp_addr_q.size() != 0) begin
                        void'(exp_addr_q.pop_front());
                        void'(exp_data_q.pop_front());
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    function automatic logic [7:0] frame_csum(input logic [31:0] addr, input logic [15:0] len,
                                              input bytes_t data);
        logic [7:0] c;
        c = addr[7:0] ^ addr[15:8] ^ addr[23:16] ^ addr[31:24] ^ len[7:0] ^ len[15:8];
        foreach (data[i]) c = c ^ data[i];
        return c;
    endfunction

    task automatic build_frame(input logic [31:0] addr, input logic [15:0] len, input bytes_t data,
                               input logic [7:0] csum_xor, output bytes_t f);
        f = {};
        f.push_back(8'hA5);
        for (int i = 0; i < 4; i++) f.push_back(addr[8*i +: 8]);
        f.push_back(len[7:0]);
        f.push_back(len[15:8]);
        foreach (data[i]) f.push_back(data[i]);
        f.push_back(frame_csum(addr, len, data) ^ csum_xor);
    endtask

    task automatic model_writes(input logic [31:0] addr, input logic [15:0] len, input bytes_t data);
        for (int w = 0; w < int'(len); w++) begin
            exp_addr_q.push_back(addr + 32'(4 * w));
            exp_data_q.push_back({data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]});
        end
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        bus_if.rx_data       = b;
        bus_if.rx_data_valid = 1'b1;
        repeat (hold) @(negedge clk);
        bus_if.rx_data_valid = 1'b0;
        bus_if.rx_data       = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bytes(input bytes_t q, input int hold, input int gap);
        foreach (q[i]) send_byte(q[i], hold, gap);
    endtask

    task automatic check_outcome(input string name, input int boot0, input int exp_boot,
                                 input logic [1:0] exp_err, input logic exp_hold);
        repeat (20) @(negedge clk);
        check({name, "_boot_go"},   64'(boot_cnt - boot0), 64'(exp_boot));
        check({name, "_err"},       64'(bus_if.err), 64'(exp_err));
        check({name, "_core_hold"}, 64'(bus_if.core_hold), 64'(exp_hold));
        check({name, "_mem_req"},   64'(bus_if.mem_req), 64'd0);
        check({name, "_writes"},    64'(exp_addr_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_mem_req"},   64'(bus_if.mem_req), 64'd0);
        check({name, "_mem_addr"},  64'(bus_if.mem_addr), 64'd0);
        check({name, "_mem_wdata"}, 64'(bus_if.mem_wdata), 64'd0);
        check({name, "_core_hold"}, 64'(bus_if.core_hold), 64'd0);
        check({name, "_boot_go"},   64'(bus_if.boot_go), 64'd0);
        check({name, "_err"},       64'(bus_if.err), 64'd0);
    endtask

    initial begin
        bytes_t t1, f, d, none;
        int b0;

        rst = 1'b1;
        bus_if.rx_data_valid = 1'b0;
        bus_if.rx_data       = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, literal bytes and literal expected writes.
        t1 = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h9A};
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        check("model_csum_pin", 64'(frame_csum(32'h1000, 16'd2, d)), 64'h9A);
        none = {};
        check("model_len0_csum_pin", 64'(frame_csum(32'h3000, 16'd0, none)), 64'h30);

        ack_lat = 3;
        push_write(32'h1000, 32'h4433_2211);
        push_write(32'h1004, 32'h8877_6655);
        b0 = boot_cnt;
        send_bytes(t1, 1, 2);
        check_outcome("basic", b0, 1, 2'd0, 1'b0);

        // Corrupted checksum: writes still happen, no boot.
        t1[15] = 8'h9B;
        push_write(32'h1000, 32'h4433_2211);
        push_write(32'h1004, 32'h8877_6655);
        b0 = boot_cnt;
        send_bytes(t1, 1, 2);
        check_outcome("bad_csum", b0, 0, 2'd1, 1'b1);

        // Valid held high for 400 cycles per byte.
        t1[15] = 8'h9A;
        push_write(32'h1000, 32'h4433_2211);
        push_write(32'h1004, 32'h8877_6655);
        b0 = boot_cnt;
        send_bytes(t1, 400, 1);
        check_outcome("long_valid", b0, 1, 2'd0, 1'b0);

        // Timeout after two ADDR bytes.
        send_byte(8'hA5, 1, 1);
        send_byte(8'h00, 1, 1);
        send_byte(8'h10, 1, 1);
        repeat (TIMEOUT - 10) @(negedge clk);
        check("timeout_early_err", 64'(bus_if.err), 64'd0);
        check("timeout_core_hold", 64'(bus_if.core_hold), 64'd1);
        repeat (20) @(negedge clk);
        check("timeout_err", 64'(bus_if.err), 64'd2);
        check("timeout_mem_req", 64'(bus_if.mem_req), 64'd0);

        // Overrun: ack never arrives, second word completes.
        ack_off = 1'b1;
        push_write(32'h1000, 32'h4433_2211);
        for (int i = 0; i < 15; i++) send_byte(t1[i], 1, 2);
        repeat (5) @(negedge clk);
        check("overrun_err", 64'(bus_if.err), 64'd3);
        check("overrun_mem_req", 64'(bus_if.mem_req), 64'd0);
        check("overrun_core_hold", 64'(bus_if.core_hold), 64'd1);
        exp_addr_q = {};
        exp_data_q = {};
        ack_off = 1'b0;

        // LEN = 0: no writes, boot.
        build_frame(32'h3000, 16'd0, none, 8'h00, f);
        b0 = boot_cnt;
        send_bytes(f, 1, 1);
        check_outcome("len0", b0, 1, 2'd0, 1'b0);

        // Misaligned address.
        send_bytes('{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00}, 1, 1);
        repeat (5) @(negedge clk);
        check("misalign_err", 64'(bus_if.err), 64'd3);
        check("misalign_mem_req", 64'(bus_if.mem_req), 64'd0);
        check("misalign_core_hold", 64'(bus_if.core_hold), 64'd1);

        // Address wrap.
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        build_frame(32'hFFFF_FFFC, 16'd2, d, 8'h00, f);
        push_write(32'hFFFF_FFFC, 32'h0403_0201);
        push_write(32'h0000_0000, 32'h0807_0605);
        b0 = boot_cnt;
        send_bytes(f, 1, 2);
        check_outcome("wrap", b0, 1, 2'd0, 1'b0);

        // Reset in the middle of DATA with a write pending.
        ack_off = 1'b1;
        push_write(32'h2000, 32'h4433_2211);
        send_bytes('{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00,
                     8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 1, 1);
        check("pre_rst_mem_req", 64'(bus_if.mem_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        rst = 1'b0;
        exp_addr_q = {};
        exp_data_q = {};
        ack_off = 1'b0;
        @(negedge clk);

        // Random frames against the model.
        for (int n = 0; n < 25; n++) begin
            logic [31:0] addr;
            logic [15:0] len;
            logic [7:0]  cx;
            int hold, gap, sel;
            bit misal;
            hold    = $urandom_range(1, 4);
            gap     = $urandom_range(1, 4);
            ack_lat = $urandom_range(0, 5);
            sel     = $urandom_range(0, 9);
            len     = 16'($urandom_range(0, 6));
            addr    = {$urandom, 2'b00} >> 0;
            addr[1:0] = 2'b00;
            if (sel == 0) addr = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            misal = (sel == 1);
            if (misal) addr[1:0] = 2'($urandom_range(1, 3));
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            d = {};
            for (int i = 0; i < 4 * int'(len); i++) d.push_back(8'($urandom));
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                logic [7:0] junk;
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, hold, gap);
            end
            build_frame(addr, len, d, cx, f);
            b0 = boot_cnt;
            if (misal) begin
                for (int i = 0; i < 5; i++) send_byte(f[i], hold, gap);
                check_outcome("rand_misalign", b0, 0, 2'd3, 1'b1);
            end else begin
                model_writes(addr, len, d);
                send_bytes(f, hold, gap);
                if (cx != 8'h00) check_outcome("rand_bad_csum", b0, 0, 2'd1, 1'b1);
                else             check_outcome("rand_good", b0, 1, 2'd0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
